// File: rtl/timebase_pkg.sv
// Shared time-field types, constants and saturation helper for the timebase and stopwatch blocks.
package timebase_pkg;

    localparam int SECS_PER_MIN = 60;
    localparam int MINS_PER_HR  = 60;
    localparam int SEC_W        = 6;
    localparam int MIN_W        = 6;
    localparam int HMS_HRS_W    = 7;

    typedef logic [SEC_W-1:0] sec_t;
    typedef logic [MIN_W-1:0] min_t;

    // Default-width H:M:S word; blocks with a different hours width declare the same layout locally.
    typedef struct packed {
        logic [HMS_HRS_W-1:0] hrs;
        min_t                 min;
        sec_t                 sec;
    } hms_t;

    function automatic int unsigned sat_field(input int unsigned val, input int unsigned max_val);
        return (val > max_val) ? max_val : val;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Clock prescaler: counts 0..CYCLES_PER_TICK-1 while enabled and strobes tick_evt on the last count.
module tick_prescaler #(
    parameter int CYCLES_PER_TICK = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clr,
    output logic tick_evt
);

    localparam int              CNT_W = $clog2(CYCLES_PER_TICK);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES_PER_TICK - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick_evt = enable && (cnt_q == LAST);

    always_comb begin
        // NOTE: default first so every path assigns cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick_evt) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        // NOTE: non-blocking so all registers sample pre-edge values together.
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/timebase_gen.sv
// Programmable timebase: prescaled tick, sub-tick, H:M:S counters, strobes and cumulative tick count.
// Optional alarm compare is built only when TIMEBASE_ALARM_EN is defined.
module timebase_gen
    import timebase_pkg::*;
#(
    parameter int CYCLES_PER_TICK = 1024,
    parameter int TICKS_PER_SEC   = 2,
    parameter int HRS_MAX         = 99,
    parameter int HRS_W           = 7,
    parameter int CUM_W           = 19
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   clear,
    input  logic                   load,
    input  logic [HRS_W+12-1:0]    load_hms,
    input  logic [HRS_W+12-1:0]    alarm_hms,
    output logic [HRS_W+12-1:0]    hms_time,
    output logic [CUM_W-1:0]       tick_cum,
    output logic                   tick_pulse,
    output logic                   sec_pulse,
    output logic                   min_pulse,
    output logic                   rollover,
    output logic                   alarm_pulse
);

    localparam int SUB_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

    typedef struct packed {
        logic [HRS_W-1:0] hrs;
        min_t             min;
        sec_t             sec;
    } hms_w_t;

    logic             tick_evt;
    logic             presc_clr;
    hms_w_t           ld_hms;
    hms_w_t           hms_q, hms_d;
    logic [SUB_W-1:0] sub_q, sub_d;
    logic [CUM_W-1:0] cum_q, cum_d;
    logic             tick_q, tick_d;
    logic             sec_q, sec_d;
    logic             min_q, min_d;
    logic             roll_q, roll_d;
    logic             alarm_q, alarm_d;

    // A clear or load restarts the tick phase and swallows any tick on the same edge.
    assign presc_clr = clear | load;
    assign ld_hms    = hms_w_t'(load_hms);

    tick_prescaler #(
        .CYCLES_PER_TICK(CYCLES_PER_TICK)
    ) u_prescaler (
        .clock   (clock),
        .reset   (reset),
        .enable  (enable),
        .clr     (presc_clr),
        .tick_evt(tick_evt)
    );

    always_comb begin
        hms_d  = hms_q;
        sub_d  = sub_q;
        cum_d  = cum_q;
        tick_d = 1'b0;
        sec_d  = 1'b0;
        min_d  = 1'b0;
        roll_d = 1'b0;
        if (clear) begin
            hms_d = '0;
            sub_d = '0;
            cum_d = '0;
        end else if (load) begin
            hms_d.hrs = HRS_W'(sat_field(32'(ld_hms.hrs), HRS_MAX));
            hms_d.min = min_t'(sat_field(32'(ld_hms.min), MINS_PER_HR - 1));
            hms_d.sec = sec_t'(sat_field(32'(ld_hms.sec), SECS_PER_MIN - 1));
            sub_d     = '0;
        end else if (tick_evt) begin
            cum_d  = cum_q + CUM_W'(1);
            tick_d = 1'b1;
            if (sub_q == SUB_W'(TICKS_PER_SEC - 1)) begin
                sub_d = '0;
                sec_d = 1'b1;
                if (hms_q.sec == sec_t'(SECS_PER_MIN - 1)) begin
                    hms_d.sec = '0;
                    min_d     = 1'b1;
                    if (hms_q.min == min_t'(MINS_PER_HR - 1)) begin
                        hms_d.min = '0;
                        if (hms_q.hrs == HRS_W'(HRS_MAX)) begin
                            hms_d.hrs = '0;
                            roll_d    = 1'b1;
                        end else begin
                            hms_d.hrs = hms_q.hrs + HRS_W'(1);
                        end
                    end else begin
                        hms_d.min = hms_q.min + min_t'(1);
                    end
                end else begin
                    hms_d.sec = hms_q.sec + sec_t'(1);
                end
            end else begin
                sub_d = sub_q + SUB_W'(1);
            end
        end
    end

`ifdef TIMEBASE_ALARM_EN
    // The counted time is always in range, so an out-of-range alarm value can never be equal.
    assign alarm_d = sec_d && (hms_d == hms_w_t'(alarm_hms));
`else
    logic alarm_unused;
    assign alarm_unused = ^alarm_hms;
    assign alarm_d      = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hms_q   <= '0;
            sub_q   <= '0;
            cum_q   <= '0;
            tick_q  <= 1'b0;
            sec_q   <= 1'b0;
            min_q   <= 1'b0;
            roll_q  <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            hms_q   <= hms_d;
            sub_q   <= sub_d;
            cum_q   <= cum_d;
            tick_q  <= tick_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            roll_q  <= roll_d;
            alarm_q <= alarm_d;
        end
    end

    assign hms_time    = hms_q;
    assign tick_cum    = cum_q;
    assign tick_pulse  = tick_q;
    assign sec_pulse   = sec_q;
    assign min_pulse   = min_q;
    assign rollover    = roll_q;
    assign alarm_pulse = alarm_q;

endmodule

// File: doc/timebase_gen.md
Name: timebase_gen

Overview:
- Parametrised successor of the fixed 1024-cycle half-second timer.
- Divides the system clock into a programmable tick; counts sub-ticks, seconds, minutes and hours up to HRS_MAX.
- Emits single-cycle tick, second, minute and rollover strobes, a packed H:M:S word and a cumulative tick count.
- Adds run/pause, synchronous clear and time preload. Feeds the display and stopwatch logic.

Parameters:
- CYCLES_PER_TICK, 1024: clock cycles per tick; must be >= 2.
- TICKS_PER_SEC, 2: ticks per second; must be >= 1.
- HRS_MAX, 99: highest hour value before wrapping to 0.
- HRS_W, 7: hours field width; must satisfy 2^HRS_W > HRS_MAX.
- CUM_W, 19: cumulative tick counter width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  1 = run, 0 = freeze all counters.
- clear  in  1  synchronous zero of all counters.
- load  in  1  synchronous preload of H:M:S from load_hms.
- load_hms  in  HRS_W+12  {hrs, min[5:0], sec[5:0]}.
- alarm_hms  in  HRS_W+12  alarm compare value; used only with ALARM_EN.
- hms_time  out  HRS_W+12  {hrs, min, sec}.
- tick_cum  out  CUM_W  ticks since reset or clear.
- tick_pulse  out  1  one-cycle strobe per tick.
- sec_pulse  out  1  one-cycle strobe per second.
- min_pulse  out  1  one-cycle strobe per minute.
- rollover  out  1  one-cycle strobe on HRS_MAX:59:59 -> 0:00:00.
- alarm_pulse  out  1  one-cycle alarm strobe.

Behaviour:
- Reset (async) forces every counter, every output and every strobe to 0.
- Priority at each clock edge, highest first: reset, clear, load, enable-gated counting.
- Prescaler:
  - counts 0..CYCLES_PER_TICK-1 while enable=1, holds its value while enable=0;
  - tick_evt is asserted when prescaler = CYCLES_PER_TICK-1 and enable=1;
  - the prescaler wraps to 0 on that same edge.
- Strobe timing:
  - all strobes are registered; each is high for exactly the one cycle after the edge that consumed tick_evt;
  - the counter outputs update on that same edge.
- Sub-tick counter:
  - counts 0..TICKS_PER_SEC-1 on tick_evt;
  - on wrap, sec_evt is asserted and seconds increment.
- Seconds: 0..59; on wrap they go to 0, minutes increment and min_pulse is asserted together with sec_pulse.
- Minutes: 0..59; on wrap they go to 0 and hours increment.
- Hours: 0..HRS_MAX; at HRS_MAX:59:59 plus one second all fields go to 0 and rollover fires. rollover coincides with sec_pulse and min_pulse.
- tick_cum:
  - increments on every tick_evt and wraps modulo 2^CUM_W;
  - is NOT cleared by time rollover or by load, only by reset or clear.
- clear: zeroes prescaler, sub-tick, H:M:S and tick_cum; no strobes in the following cycle.
- load:
  - H:M:S takes load_hms; prescaler and sub-tick go to 0;
  - tick_cum is kept;
  - no strobes in the following cycle;
  - out-of-range fields saturate: sec>59 -> 59, min>59 -> 59, hrs>HRS_MAX -> HRS_MAX.
- A tick_evt in the same cycle as clear or load is discarded.
- enable=0: all counters and outputs hold; no strobes.
- Any pending strobe from the previous edge still completes its one cycle.

Optional Feature:
- Macro: TIMEBASE_ALARM_EN.
- Defined: alarm_pulse fires for one cycle (aligned with sec_pulse) when a counted second transition makes H:M:S equal alarm_hms.
  - A load to that value does not fire it.
  - An alarm_hms with out-of-range fields never matches.
- Undefined: compare logic is absent, alarm_pulse is tied to 0 and alarm_hms is ignored. The port list is unchanged.

Decomposition:
- Package timebase_pkg:
  - SECS_PER_MIN=60, MINS_PER_HR=60, SEC_W=6, MIN_W=6;
  - an hms_t packed-struct typedef parametrised by HRS_W via localparam;
  - saturation helper function sat_field.
- One sub-module, tick_prescaler: parameter CYCLES_PER_TICK; ports clock, reset, enable, clr; output tick_evt. It is reused by the stopwatch block.

Test Plan (CYCLES_PER_TICK=4, TICKS_PER_SEC=2, HRS_MAX=2, HRS_W=2, CUM_W=8 unless noted):
- Reset release, enable=1 for 16 cycles -> tick_pulse every 4th cycle (4 pulses), sec_pulse every 8th (2 pulses), hms_time=0:00:02, tick_cum=4.
- load 2:59:58, run 2 s -> sec_pulse at 2:59:59; next second gives min_pulse, sec_pulse and rollover together, hms_time=0, tick_cum continues.
- load with sec=63, min=60, hrs=3 -> hms_time=2:59:59; no strobes in the next cycle; prescaler restarts at 0.
- enable=0 for 10 cycles mid-tick, then 1 -> tick delayed by exactly 10 cycles; no strobes while paused.
- clear asserted in the same cycle as tick_evt -> all counters 0, tick_cum=0, no strobes; CUM_W=3 run for 9 ticks -> tick_cum wraps to 1.
- TIMEBASE_ALARM_EN defined:
  - alarm_hms=0:00:03 -> single alarm_pulse coincident with the third sec_pulse;
  - load 0:00:03 -> no alarm_pulse.
